// File: rtl/seg7_scan_driver.sv
// Time-multiplexed, double-buffered driver for an N-digit common-anode seven-segment display.
// Define SEG7_HEX_EN to decode codes 10..15 as hex glyphs; otherwise those codes are blank.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic [4*NUM_DIGITS-1:0]   iDIGITS,
  input  logic                      iLOAD,
  input  logic                      iBLANK_LZ,
  output logic [6:0]                oSEG7,
  output logic [NUM_DIGITS-1:0]     oDIG_SEL,
  output logic                      oFRAME
);

  localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] TICK_VAL = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF  = 7'b1111111;

  logic [CNT_W-1:0]      prescaler;
  logic [IDX_W-1:0]      idx;
  logic [DATA_W-1:0]     pending;
  logic [DATA_W-1:0]     display;
  logic                  wrapDly;
  logic                  tick;
  logic                  wrap;
  logic [3:0]            code;
  logic [NUM_DIGITS-1:0] zeroFrom;
  logic                  blankDigit;
  logic [6:0]            segNext;
  logic [NUM_DIGITS-1:0] selNext;

  function automatic logic [6:0] decodeSeg(input logic [3:0] c);
    logic [6:0] s;
    s = SEG_OFF;
    case (c)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
`ifdef SEG7_HEX_EN
      4'd10:   s = 7'b0001000;
      4'd11:   s = 7'b0000011;
      4'd12:   s = 7'b1000110;
      4'd13:   s = 7'b0100001;
      4'd14:   s = 7'b0000110;
      4'd15:   s = 7'b0001110;
`endif
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  assign tick = (prescaler == TICK_VAL);
  assign wrap = tick && (idx == LAST_IDX);

  // Digit dwell prescaler
  always_ff @(posedge iCLK) begin
    if (iRST)      prescaler <= '0;
    else if (tick) prescaler <= '0;
    else           prescaler <= prescaler + CNT_W'(1);
  end

  always_ff @(posedge iCLK) begin
    if (iRST)      idx <= '0;
    else if (tick) idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  end

  // Double buffer: a load on the wrap cycle bypasses straight to the display
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pending <= '0;
      display <= '0;
    end else begin
      if (iLOAD) pending <= iDIGITS;
      if (wrap)  display <= iLOAD ? iDIGITS : pending;
    end
  end

  // zeroFrom[i] is set when nibble i and every nibble above it are zero
  always_comb begin
    zeroFrom = '0;
    zeroFrom[NUM_DIGITS-1] = (display[DATA_W-1 -: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zeroFrom[i] = zeroFrom[i+1] && (display[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    code       = display[{idx, 2'b00} +: 4];
    blankDigit = iBLANK_LZ && (idx != '0) && zeroFrom[idx];
    segNext    = blankDigit ? SEG_OFF : decodeSeg(code);
    selNext    = ~(NUM_DIGITS'(1) << idx);
  end

  // Frame pulse is delayed twice so it coincides with digit 0 on the pins
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oSEG7    <= SEG_OFF;
      oDIG_SEL <= '1;
      wrapDly  <= 1'b0;
      oFRAME   <= 1'b0;
    end else begin
      oSEG7    <= segNext;
      oDIG_SEL <= selNext;
      wrapDly  <= wrap;
      oFRAME   <= wrapDly;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed, table-driven bench for seg7_scan_driver with 4 digits and a 4-clock dwell.
module tb_seg7_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 4;
  localparam int LAST_CYC = 160;

`ifdef SEG7_HEX_EN
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_F = 7'b0001110;
`else
  localparam logic [6:0] GLYPH_A = 7'b1111111;
  localparam logic [6:0] GLYPH_F = 7'b1111111;
`endif

  logic           iCLK;
  logic           iRST;
  logic [4*ND-1:0] iDIGITS;
  logic           iLOAD;
  logic           iBLANK_LZ;
  logic [6:0]     oSEG7;
  logic [ND-1:0]  oDIG_SEL;
  logic           oFRAME;

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDIGITS(iDIGITS), .iLOAD(iLOAD),
    .iBLANK_LZ(iBLANK_LZ), .oSEG7(oSEG7), .oDIG_SEL(oDIG_SEL), .oFRAME(oFRAME)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    int          cyc;
    logic        isChk;
    logic        doLoad;
    logic [15:0] digits;
    logic        setBlank;
    logic        blankVal;
    logic        doRst;
    logic [6:0]  seg;
    logic [3:0]  sel;
  } vec_t;

  vec_t vecs[$];
  int   vecCnt = 0;
  int   missCnt = 0;
  int   base = 0;

  function automatic vec_t mkStim(int c, logic ld, logic [15:0] d, logic sb, logic bv, logic r);
    vec_t v;
    v.cyc = c; v.isChk = 1'b0; v.doLoad = ld; v.digits = d;
    v.setBlank = sb; v.blankVal = bv; v.doRst = r;
    v.seg = '1; v.sel = '1;
    return v;
  endfunction

  function automatic vec_t mkChk(int c, logic [6:0] s, logic [3:0] sl);
    vec_t v;
    v.cyc = c; v.isChk = 1'b1; v.doLoad = 1'b0; v.digits = '0;
    v.setBlank = 1'b0; v.blankVal = 1'b0; v.doRst = 1'b0;
    v.seg = s; v.sel = sl;
    return v;
  endfunction

  task automatic cmp(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    vecCnt++;
    if (act !== exp) begin
      missCnt++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  initial begin
    // Stimulus: load strobes, blank-enable changes and a mid-frame reset
    vecs.push_back(mkStim(2,   1'b1, 16'h1234, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkStim(20,  1'b1, 16'h0070, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mkStim(36,  1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkStim(63,  1'b1, 16'h0009, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkStim(70,  1'b1, 16'h0005, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkStim(82,  1'b1, 16'hF0AA, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mkStim(98,  1'b1, 16'h1005, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mkStim(130, 1'b1, 16'h8888, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkStim(137, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1));
    // Expected pins (hand-decoded)
    vecs.push_back(mkChk(0,   7'b1111111, 4'b1111));
    vecs.push_back(mkChk(1,   7'b1000000, 4'b1110));
    vecs.push_back(mkChk(5,   7'b1000000, 4'b1101));
    vecs.push_back(mkChk(9,   7'b1000000, 4'b1011));
    vecs.push_back(mkChk(13,  7'b1000000, 4'b0111));
    vecs.push_back(mkChk(16,  7'b1000000, 4'b0111));
    vecs.push_back(mkChk(17,  7'b0011001, 4'b1110));
    vecs.push_back(mkChk(21,  7'b0110000, 4'b1101));
    vecs.push_back(mkChk(25,  7'b0100100, 4'b1011));
    vecs.push_back(mkChk(29,  7'b1111001, 4'b0111));
    vecs.push_back(mkChk(33,  7'b1000000, 4'b1110));
    vecs.push_back(mkChk(37,  7'b1111000, 4'b1101));
    vecs.push_back(mkChk(41,  7'b1111111, 4'b1011));
    vecs.push_back(mkChk(45,  7'b1111111, 4'b0111));
    vecs.push_back(mkChk(49,  7'b1000000, 4'b1110));
    vecs.push_back(mkChk(53,  7'b1111111, 4'b1101));
    vecs.push_back(mkChk(57,  7'b1111111, 4'b1011));
    vecs.push_back(mkChk(61,  7'b1111111, 4'b0111));
    vecs.push_back(mkChk(65,  7'b0010000, 4'b1110));
    vecs.push_back(mkChk(68,  7'b0010000, 4'b1110));
    vecs.push_back(mkChk(69,  7'b1111111, 4'b1101));
    vecs.push_back(mkChk(81,  7'b0010010, 4'b1110));
    vecs.push_back(mkChk(97,  GLYPH_A,    4'b1110));
    vecs.push_back(mkChk(101, GLYPH_A,    4'b1101));
    vecs.push_back(mkChk(105, 7'b1000000, 4'b1011));
    vecs.push_back(mkChk(109, GLYPH_F,    4'b0111));
    vecs.push_back(mkChk(113, 7'b0010010, 4'b1110));
    vecs.push_back(mkChk(117, 7'b1000000, 4'b1101));
    vecs.push_back(mkChk(121, 7'b1000000, 4'b1011));
    vecs.push_back(mkChk(125, 7'b1111001, 4'b0111));
    vecs.push_back(mkChk(138, 7'b1111111, 4'b1111));
    vecs.push_back(mkChk(139, 7'b1000000, 4'b1110));
    vecs.push_back(mkChk(143, 7'b1111111, 4'b1101));
    vecs.push_back(mkChk(155, 7'b1000000, 4'b1110));

    iRST = 1'b1; iLOAD = 1'b0; iDIGITS = '0; iBLANK_LZ = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    iRST = 1'b0;

    for (int c = 0; c <= LAST_CYC; c++) begin
      int rel;
      logic expFrame;
      rel = c - base;
      expFrame = (rel >= 17) && (((rel - 1) % 16) == 0);
      cmp("oFRAME", c, 32'(oFRAME), 32'(expFrame));
      if (rel >= 1) cmp("onehot", c, 32'($countones(~oDIG_SEL)), 32'd1);
      foreach (vecs[k]) begin
        if (vecs[k].cyc == c) begin
          if (vecs[k].isChk) begin
            cmp("oSEG7", c, 32'(oSEG7), 32'(vecs[k].seg));
            cmp("oDIG_SEL", c, 32'(oDIG_SEL), 32'(vecs[k].sel));
          end else begin
            if (vecs[k].doLoad) begin
              iLOAD = 1'b1;
              iDIGITS = vecs[k].digits;
            end
            if (vecs[k].setBlank) iBLANK_LZ = vecs[k].blankVal;
            if (vecs[k].doRst) begin
              iRST = 1'b1;
              base = c + 1;
            end
          end
        end
      end
      @(posedge iCLK);
      #1;
      iLOAD = 1'b0;
      iRST = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
